// File: rtl/trap_ctrl_pkg.sv
// Shared constants and types for the machine-mode trap sequencer.
package trap_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CSR_AW = 12;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
    localparam logic [CSR_AW-1:0] CSR_MTVAL   = 12'h343;

    localparam logic [XLEN-1:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [XLEN-1:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [XLEN-1:0] CAUSE_ECALL   = 32'd11;
    localparam logic [XLEN-1:0] CAUSE_MEI     = 32'h8000_000B;
    localparam logic [XLEN-1:0] CAUSE_MSI     = 32'h8000_0003;
    localparam logic [XLEN-1:0] CAUSE_MTI     = 32'h8000_0007;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MEPC     = 3'd1,
        S_MCAUSE   = 3'd2,
        S_MTVAL    = 3'd3,
        S_MSTATUS  = 3'd4,
        S_JUMP     = 3'd5,
        S_MRET_ST  = 3'd6,
        S_MRET_JMP = 3'd7
    } trap_state_e;

    // Context captured on the accept cycle and replayed into the CSRs.
    typedef struct packed {
        logic [XLEN-1:0] epc;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            mie;
        logic            mpie;
    } trap_ctx_t;

    function automatic logic [XLEN-1:0] mstatus_word(input logic mpie, input logic mie);
        logic [XLEN-1:0] w;
        w               = '0;
        w[MSTATUS_MPIE] = mpie;
        w[MSTATUS_MIE]  = mie;
        return w;
    endfunction

endpackage

// File: rtl/trap_prio.sv
// Priority encoder for trap sources: exceptions, then mret, then masked interrupts.
module trap_prio
    import trap_ctrl_pkg::*;
(
    input  logic            inst_valid_i,
    input  logic            illegal_i,
    input  logic            ebreak_i,
    input  logic            ecall_i,
    input  logic            mret_i,
    input  logic            mie_i,
    input  logic            ex_trap_i,
    input  logic            soft_trap_i,
    input  logic            tcmp_trap_i,
    output logic            take_o,
    output logic            is_mret_o,
    output logic [XLEN-1:0] cause_o
);

    always_comb begin
        take_o    = 1'b0;
        is_mret_o = 1'b0;
        cause_o   = '0;
        if (inst_valid_i) begin
            take_o = 1'b1;
            if (illegal_i)                  cause_o = CAUSE_ILLEGAL;
            else if (ebreak_i)              cause_o = CAUSE_EBREAK;
            else if (ecall_i)               cause_o = CAUSE_ECALL;
            else if (mret_i)                is_mret_o = 1'b1;
            else if (mie_i && ex_trap_i)    cause_o = CAUSE_MEI;
            else if (mie_i && soft_trap_i)  cause_o = CAUSE_MSI;
            else if (mie_i && tcmp_trap_i)  cause_o = CAUSE_MTI;
            else                            take_o = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: saves/restores trap CSRs over the csr trap channel
// while holding the pipeline, then redirects the PC to mtvec or mepc.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid_i,
    input  logic [XLEN-1:0]   cur_pc_i,
    input  logic [XLEN-1:0]   inst_i,
    input  logic              ecall_i,
    input  logic              ebreak_i,
    input  logic              illegal_i,
    input  logic              mret_i,
    input  logic              ex_trap_i,
    input  logic              tcmp_trap_i,
    input  logic              soft_trap_i,
    output logic              trap_csr_we_o,
    output logic [CSR_AW-1:0] trap_csr_addr_o,
    output logic [XLEN-1:0]   trap_csr_wdata_o,
    input  logic [XLEN-1:0]   trap_csr_rdata_i,
    output logic              kill_o,
    output logic              hold_o,
    output logic              jump_o,
    output logic [XLEN-1:0]   jump_addr_o
);

    trap_state_e     state_q, state_d;
    trap_ctx_t       ctx_q, ctx_d;
    logic            take;
    logic            is_mret;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] vec_off;

    // In IDLE the channel addresses mstatus, so rdata carries the live MIE/MPIE bits.
    trap_prio u_prio (
        .inst_valid_i (inst_valid_i),
        .illegal_i    (illegal_i),
        .ebreak_i     (ebreak_i),
        .ecall_i      (ecall_i),
        .mret_i       (mret_i),
        .mie_i        (trap_csr_rdata_i[MSTATUS_MIE]),
        .ex_trap_i    (ex_trap_i),
        .soft_trap_i  (soft_trap_i),
        .tcmp_trap_i  (tcmp_trap_i),
        .take_o       (take),
        .is_mret_o    (is_mret),
        .cause_o      (cause)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctx_q   <= '0;
        end else begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        ctx_d            = ctx_q;
        vec_off          = '0;
        trap_csr_we_o    = 1'b0;
        trap_csr_addr_o  = CSR_MSTATUS;
        trap_csr_wdata_o = '0;
        kill_o           = 1'b0;
        hold_o           = 1'b0;
        jump_o           = 1'b0;
        jump_addr_o      = '0;

        case (state_q)
            S_IDLE: begin
                if (take) begin
                    kill_o     = 1'b1;
                    hold_o     = 1'b1;
                    ctx_d.epc  = cur_pc_i;
                    ctx_d.cause = cause;
                    ctx_d.mie  = trap_csr_rdata_i[MSTATUS_MIE];
                    ctx_d.mpie = trap_csr_rdata_i[MSTATUS_MPIE];
                    if (cause == CAUSE_ILLEGAL)     ctx_d.tval = inst_i;
                    else if (cause == CAUSE_EBREAK) ctx_d.tval = cur_pc_i;
                    else                            ctx_d.tval = '0;
                    state_d = is_mret ? S_MRET_ST : S_MEPC;
                end
            end
            S_MEPC: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MEPC;
                trap_csr_wdata_o = ctx_q.epc;
                hold_o           = 1'b1;
                state_d          = S_MCAUSE;
            end
            S_MCAUSE: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MCAUSE;
                trap_csr_wdata_o = ctx_q.cause;
                hold_o           = 1'b1;
                state_d          = S_MTVAL;
            end
            S_MTVAL: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MTVAL;
                trap_csr_wdata_o = ctx_q.tval;
                hold_o           = 1'b1;
                state_d          = S_MSTATUS;
            end
            S_MSTATUS: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MSTATUS;
                trap_csr_wdata_o = mstatus_word(ctx_q.mie, 1'b0);
                hold_o           = 1'b1;
                state_d          = S_JUMP;
            end
            S_JUMP: begin
                // Vectored entry only for interrupts; offset wraps in 32 bits.
                trap_csr_addr_o = CSR_MTVEC;
                hold_o          = 1'b1;
                jump_o          = 1'b1;
                if (VECTORED_EN && trap_csr_rdata_i[0] && ctx_q.cause[XLEN-1])
                    vec_off = {ctx_q.cause[XLEN-3:0], 2'b00};
                jump_addr_o = {trap_csr_rdata_i[XLEN-1:2], 2'b00} + vec_off;
                state_d     = S_IDLE;
            end
            S_MRET_ST: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MSTATUS;
                trap_csr_wdata_o = mstatus_word(1'b1, ctx_q.mpie);
                hold_o           = 1'b1;
                state_d          = S_MRET_JMP;
            end
            S_MRET_JMP: begin
                trap_csr_addr_o = CSR_MEPC;
                hold_o          = 1'b1;
                jump_o          = 1'b1;
                jump_addr_o     = trap_csr_rdata_i;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Reset forces quiet outputs immediately, even mid-sequence.
        if (rst) begin
            trap_csr_we_o    = 1'b0;
            trap_csr_addr_o  = CSR_MSTATUS;
            trap_csr_wdata_o = '0;
            kill_o           = 1'b0;
            hold_o           = 1'b0;
            jump_o           = 1'b0;
            jump_addr_o      = '0;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed cases plus randomized transactions
// compared against a behavioural model of the trap rules and a small CSR stub.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid_i, ecall_i, ebreak_i, illegal_i, mret_i;
    logic        ex_trap_i, tcmp_trap_i, soft_trap_i;
    logic [31:0] cur_pc_i, inst_i;
    logic        trap_csr_we_o;
    logic [11:0] trap_csr_addr_o;
    logic [31:0] trap_csr_wdata_o, trap_csr_rdata_i;
    logic        kill_o, hold_o, jump_o;
    logic [31:0] jump_addr_o;

    logic [31:0] r_mstatus, r_mtvec, r_mepc, r_mcause, r_mtval;
    int errors = 0;
    int checks = 0;

    trap_ctrl #(.VECTORED_EN(1'b1)) dut (
        .clk              (clk),
        .rst              (rst),
        .inst_valid_i     (inst_valid_i),
        .cur_pc_i         (cur_pc_i),
        .inst_i           (inst_i),
        .ecall_i          (ecall_i),
        .ebreak_i         (ebreak_i),
        .illegal_i        (illegal_i),
        .mret_i           (mret_i),
        .ex_trap_i        (ex_trap_i),
        .tcmp_trap_i      (tcmp_trap_i),
        .soft_trap_i      (soft_trap_i),
        .trap_csr_we_o    (trap_csr_we_o),
        .trap_csr_addr_o  (trap_csr_addr_o),
        .trap_csr_wdata_o (trap_csr_wdata_o),
        .trap_csr_rdata_i (trap_csr_rdata_i),
        .kill_o           (kill_o),
        .hold_o           (hold_o),
        .jump_o           (jump_o),
        .jump_addr_o      (jump_addr_o)
    );

    always #5 clk = ~clk;

    // Asynchronous-read CSR stub.
    always_comb begin
        case (trap_csr_addr_o)
            CSR_MSTATUS: trap_csr_rdata_i = r_mstatus;
            CSR_MTVEC:   trap_csr_rdata_i = r_mtvec;
            CSR_MEPC:    trap_csr_rdata_i = r_mepc;
            CSR_MCAUSE:  trap_csr_rdata_i = r_mcause;
            CSR_MTVAL:   trap_csr_rdata_i = r_mtval;
            default:     trap_csr_rdata_i = 32'h0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        case (a)
            CSR_MSTATUS: r_mstatus = d;
            CSR_MTVEC:   r_mtvec   = d;
            CSR_MEPC:    r_mepc    = d;
            CSR_MCAUSE:  r_mcause  = d;
            CSR_MTVAL:   r_mtval   = d;
            default: ;
        endcase
    endtask

    // ev bits: 0 valid, 1 illegal, 2 ebreak, 3 ecall, 4 mret, 5 ext, 6 soft, 7 timer
    task automatic drive_ev(input logic [7:0] ev);
        inst_valid_i = ev[0];
        illegal_i    = ev[1];
        ebreak_i     = ev[2];
        ecall_i      = ev[3];
        mret_i       = ev[4];
        ex_trap_i    = ev[5];
        soft_trap_i  = ev[6];
        tcmp_trap_i  = ev[7];
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_we"},    32'(trap_csr_we_o), 32'h0);
        check({tag, "_addr"},  32'(trap_csr_addr_o), 32'(CSR_MSTATUS));
        check({tag, "_wdata"}, trap_csr_wdata_o, 32'h0);
        check({tag, "_kill"},  32'(kill_o), 32'h0);
        check({tag, "_hold"},  32'(hold_o), 32'h0);
        check({tag, "_jump"},  32'(jump_o), 32'h0);
        check({tag, "_jaddr"}, jump_addr_o, 32'h0);
    endtask

    // One transaction: model derives the expected CSR write list, jump cycle and target.
    task automatic run_txn(input logic [31:0] pc, input logic [31:0] inst,
                           input logic [7:0] ev, input bit keep_lvls);
        bit          mie, mpie, take, is_ret;
        logic [31:0] mc, mt, jaddr, off;
        logic [11:0] ea[$];
        logic [31:0] ed[$];
        logic [11:0] wa;
        logic [31:0] wd;
        bit          do_wr;
        int          jk, nw;
        mie = r_mstatus[3]; mpie = r_mstatus[7];
        take = 0; is_ret = 0; mc = 0; mt = 0; jaddr = 0; jk = -1; nw = 0;
        if (ev[0]) begin
            take = 1;
            if (ev[1])             begin mc = 32'd2; mt = inst; end
            else if (ev[2])        begin mc = 32'd3; mt = pc;   end
            else if (ev[3])        mc = 32'd11;
            else if (ev[4])        is_ret = 1;
            else if (mie && ev[5]) mc = 32'h8000_000B;
            else if (mie && ev[6]) mc = 32'h8000_0003;
            else if (mie && ev[7]) mc = 32'h8000_0007;
            else                   take = 0;
        end
        if (take && !is_ret) begin
            ea.push_back(CSR_MEPC);    ed.push_back(pc);
            ea.push_back(CSR_MCAUSE);  ed.push_back(mc);
            ea.push_back(CSR_MTVAL);   ed.push_back(mt);
            ea.push_back(CSR_MSTATUS); ed.push_back(mie ? 32'h80 : 32'h0);
            off   = (r_mtvec[0] && mc[31]) ? ((mc & 32'h7FFF_FFFF) << 2) : 32'h0;
            jaddr = (r_mtvec & ~32'h3) + off;
            jk    = 5;
        end else if (is_ret) begin
            ea.push_back(CSR_MSTATUS); ed.push_back(32'h80 | (mpie ? 32'h8 : 32'h0));
            jaddr = r_mepc;
            jk    = 2;
        end

        @(negedge clk);
        cur_pc_i = pc; inst_i = inst;
        drive_ev(ev);
        #1;
        for (int k = 0; k < 8; k++) begin
            check("kill", 32'(kill_o), 32'(take && k == 0));
            check("hold", 32'(hold_o), 32'(take && k <= jk));
            check("jump", 32'(jump_o), 32'(k == jk));
            if (k == jk) check("jump_addr", jump_addr_o, jaddr);
            do_wr = trap_csr_we_o;
            wa = trap_csr_addr_o; wd = trap_csr_wdata_o;
            if (do_wr) begin
                if (nw < ea.size()) begin
                    check("wr_addr", 32'(wa), 32'(ea[nw]));
                    check("wr_data", wd, ed[nw]);
                end
                nw++;
            end
            @(posedge clk); #1;
            if (do_wr) csr_write(wa, wd);
            if (k == 0) drive_ev(keep_lvls ? (ev & 8'hE1) : 8'h00);
            @(negedge clk); #1;
        end
        check("n_writes", 32'(nw), 32'(ea.size()));
        drive_ev(8'h00);
    endtask

    initial begin
        cur_pc_i = 32'h500; inst_i = 32'h0;
        r_mstatus = 32'h8; r_mtvec = 32'h200; r_mepc = 0; r_mcause = 0; r_mtval = 0;
        // Reset with an ecall presented: outputs must stay quiet.
        rst = 1'b1;
        drive_ev(8'h09);
        #1;
        check_quiet("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive_ev(8'h00);
        rst = 1'b0;

        // ecall
        r_mstatus = 32'h8; r_mtvec = 32'h200;
        run_txn(32'h100, 32'h0000_0073, 8'h09, 0);
        check("ecall_mepc", r_mepc, 32'h100);
        check("ecall_mstatus", r_mstatus, 32'h80);
        // illegal, alone and together with ecall
        r_mstatus = 32'h8;
        run_txn(32'h40, 32'hFFFF_FFFF, 8'h03, 0);
        check("illegal_mtval", r_mtval, 32'hFFFF_FFFF);
        run_txn(32'h40, 32'hFFFF_FFFF, 8'h0B, 0);
        check("illegal_ecall_mcause", r_mcause, 32'd2);
        // ebreak
        run_txn(32'h88, 32'h0010_0073, 8'h05, 0);
        // vectored timer interrupt, then masked
        r_mstatus = 32'h8; r_mtvec = 32'h301;
        run_txn(32'h120, 32'h0, 8'h81, 0);
        check("mti_mcause", r_mcause, 32'h8000_0007);
        r_mstatus = 32'h0;
        run_txn(32'h124, 32'h0, 8'h81, 0);
        // all interrupts together, levels held after entry
        r_mstatus = 32'h8; r_mtvec = 32'h200;
        run_txn(32'h130, 32'h0, 8'hE1, 1);
        check("irq_all_mcause", r_mcause, 32'h8000_000B);
        // mret
        r_mepc = 32'h104; r_mstatus = 32'h80;
        run_txn(32'h300, 32'h3020_0073, 8'h11, 0);
        check("mret_mstatus", r_mstatus, 32'h88);

        // Reset pulsed while sequence sits in S_MCAUSE.
        r_mstatus = 32'h8; r_mtvec = 32'h200;
        @(negedge clk);
        cur_pc_i = 32'h600; drive_ev(8'h09);
        @(posedge clk); #1;
        drive_ev(8'h00);
        @(negedge clk); #1;
        check("rstmid_mepc_we", 32'(trap_csr_we_o), 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_quiet("rstmid");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rstmid_after_we", 32'(trap_csr_we_o), 32'h0);
            check("rstmid_after_hold", 32'(hold_o), 32'h0);
            @(negedge clk);
        end
        run_txn(32'h100, 32'h0000_0073, 8'h09, 0);

        // Randomized transactions.
        for (int n = 0; n < 60; n++) begin
            logic [7:0] ev;
            ev = 8'h00;
            ev[0] = ($urandom_range(0, 99) < 85);
            for (int b = 1; b < 8; b++) ev[b] = ($urandom_range(0, 99) < 25);
            r_mstatus = $urandom & 32'h88;
            r_mtvec   = $urandom;
            r_mepc    = $urandom;
            run_txn($urandom, $urandom, ev, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
